// File: rtl/grant_hold_ctrl_pkg.sv
// Shared definitions for the grant-hold stage: FSM encoding, default sizing
// constants and the clog2 helper used to derive id/counter widths.
package grant_hold_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_REL  = 2'b10
  } state_t;

  localparam int GH_N        = 4;
  localparam int GH_MAX_HOLD = 16;

  function automatic int gh_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/grant_hold_ctrl_onehot_enc.sv
// One-hot to binary encoder with a flag telling whether exactly one bit is set.
module onehot_enc #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_oh,
  output logic [IDW-1:0] o_id,
  output logic           o_is_onehot
);

  logic [IDW:0] w_ones;

  // OR of indices is only meaningful when o_is_onehot is set.
  always_comb begin
    o_id   = '0;
    w_ones = '0;
    for (int i = 0; i < N; i++) begin
      if (i_oh[i]) begin
        o_id   = o_id | IDW'(i);
        w_ones = w_ones + (IDW + 1)'(1);
      end
    end
    o_is_onehot = (w_ones == (IDW + 1)'(1));
  end

endmodule

// File: rtl/grant_hold_ctrl.sv
// Locks a one-hot arbiter grant into single-transaction bus ownership, with a
// forced dead cycle (REL) between owners and a bounded hold time.
module grant_hold_ctrl
  import grant_hold_ctrl_pkg::*;
#(
  parameter int N        = GH_N,
  parameter int MAX_HOLD = GH_MAX_HOLD,
  parameter int IDW      = gh_clog2(N),
  parameter int CW       = gh_clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   gnt_in,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic           owner_valid,
  output logic [IDW-1:0] owner_id,
  output logic [N-1:0]   owner_oh,
  output logic           release_p,
  output logic           timeout_err,
  output logic           onehot_err,
  output state_t         dbg_state
);

  state_t         r_state;
  logic [IDW-1:0] r_id;
  logic [CW-1:0]  r_cnt;

  logic [IDW-1:0] w_gnt_id;
  logic           w_gnt_onehot;
  logic           w_timeout;
  logic           w_withdraw;

  onehot_enc #(.N(N), .IDW(IDW)) u_enc (
    .i_oh        (gnt_in),
    .o_id        (w_gnt_id),
    .o_is_onehot (w_gnt_onehot)
  );

  assign w_timeout  = (r_cnt == CW'(MAX_HOLD - 1));
  assign w_withdraw = !req[r_id];
  assign dbg_state  = r_state;

  // Outputs are loaded with the values belonging to the next state, so they
  // change on the same edge as r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_cnt       <= '0;
      owner_valid <= 1'b0;
      owner_id    <= '0;
      owner_oh    <= '0;
      release_p   <= 1'b0;
      timeout_err <= 1'b0;
      onehot_err  <= 1'b0;
    end else begin
      release_p   <= 1'b0;
      timeout_err <= 1'b0;
      onehot_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_onehot) begin
            // A grant whose request has already dropped is stale: ignore it.
            if (req[w_gnt_id]) begin
              r_state     <= ST_OWN;
              r_id        <= w_gnt_id;
              r_cnt       <= '0;
              owner_valid <= 1'b1;
              owner_id    <= w_gnt_id;
              owner_oh    <= gnt_in;
            end
          end else if (|gnt_in) begin
            onehot_err <= 1'b1;
          end
        end
        ST_OWN: begin
          if (done || w_withdraw || w_timeout) begin
            r_state     <= ST_REL;
            r_cnt       <= '0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
            owner_oh    <= '0;
            release_p   <= 1'b1;
            // done and withdrawal outrank the timeout.
            timeout_err <= !done && !w_withdraw && w_timeout;
          end else if (r_cnt != CW'(MAX_HOLD)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_REL: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          owner_valid <= 1'b0;
          owner_id    <= '0;
          owner_oh    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// Scenario bench for grant_hold_ctrl: per-cycle expected output vectors are
// queued as stimulus is applied and popped when the DUT output is sampled.
module tb_grant_hold_ctrl;
  import grant_hold_ctrl_pkg::*;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 16;
  localparam int W        = 1 + IDW + N + 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   gnt_in;
  logic [N-1:0]   req;
  logic           done;
  logic           owner_valid;
  logic [IDW-1:0] owner_id;
  logic [N-1:0]   owner_oh;
  logic           release_p;
  logic           timeout_err;
  logic           onehot_err;
  state_t         dbg_state;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  grant_hold_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .gnt_in      (gnt_in),
    .req         (req),
    .done        (done),
    .owner_valid (owner_valid),
    .owner_id    (owner_id),
    .owner_oh    (owner_oh),
    .release_p   (release_p),
    .timeout_err (timeout_err),
    .onehot_err  (onehot_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input logic ov, input logic [IDW-1:0] id,
                                      input logic [N-1:0] oh, input logic rel,
                                      input logic to, input logic oe);
    return {ov, id, oh, rel, to, oe};
  endfunction

  function automatic logic [W-1:0] outs();
    return {owner_valid, owner_id, owner_oh, release_p, timeout_err, onehot_err};
  endfunction

  // driver: apply inputs, let one rising edge sample them, settle past it
  task automatic step(input logic [N-1:0] g, input logic [N-1:0] r, input logic d);
    gnt_in = g;
    req    = r;
    done   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] e, got;
    reset = 1'b0; gnt_in = '0; req = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", outs(), {W{1'b0}});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
    // own id 2 for three cycles, then assert reset mid-ownership
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(pk(1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b0));
      step((k == 0) ? 4'b0100 : 4'b0000, 4'b0100, 1'b0);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL reset_own[%0d] got=%b exp=%b", k, got, e); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_async got=%b exp=%b", outs(), {W{1'b0}});
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++; $display("FAIL reset_no_release got=%b exp=%b", outs(), {W{1'b0}});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_release_state got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_normal();
    logic [W-1:0] e, got;
    for (int k = 0; k < 6; k++) begin
      if (k <= 3)      exp_q.push_back(pk(1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b0));
      else if (k == 4) exp_q.push_back(pk(1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0));
      else             exp_q.push_back(pk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
      step((k == 0) ? 4'b0010 : 4'b0000, 4'b0010, k == 4);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL normal[%0d] got=%b exp=%b", k, got, e); end
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL normal_idle got=%0d exp=%0d", dbg_state, ST_IDLE);
    end
  endtask

  // with_done=1: done arrives in the last allowed owner cycle (hold_cnt=15)
  task automatic test_timeout(input logic with_done);
    logic [W-1:0] e, got;
    int ov_cycles;
    ov_cycles = 0;
    for (int k = 0; k < MAX_HOLD + 2; k++) begin
      if (k < MAX_HOLD)       exp_q.push_back(pk(1'b1, 2'd3, 4'b1000, 1'b0, 1'b0, 1'b0));
      else if (k == MAX_HOLD) exp_q.push_back(pk(1'b0, 2'd0, 4'b0000, 1'b1, !with_done, 1'b0));
      else                    exp_q.push_back(pk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
      step((k == 0) ? 4'b1000 : 4'b0000, 4'b1000, with_done && (k == MAX_HOLD));
      if (owner_valid === 1'b1) ov_cycles++;
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        failures++; $display("FAIL timeout(done=%0b)[%0d] got=%b exp=%b", with_done, k, got, e);
      end
    end
    checks++;
    if (ov_cycles != MAX_HOLD) begin
      failures++; $display("FAIL timeout_hold_len got=%0d exp=%0d", ov_cycles, MAX_HOLD);
    end
  endtask

  task automatic test_preempt_withdraw();
    logic [W-1:0] e, got;
    for (int k = 0; k < 9; k++) begin
      logic [N-1:0] g, r;
      logic d;
      d = 1'b0;
      case (k)
        0:       begin g = 4'b1000; r = 4'b1001; exp_q.push_back(pk(1, 2'd3, 4'b1000, 0, 0, 0)); end
        1, 2, 3: begin g = 4'b0001; r = 4'b1001; exp_q.push_back(pk(1, 2'd3, 4'b1000, 0, 0, 0)); end
        4:       begin g = 4'b0001; r = 4'b0001; exp_q.push_back(pk(0, 2'd0, 4'b0000, 1, 0, 0)); end
        // grant sampled during REL must be ignored
        5:       begin g = 4'b0001; r = 4'b0001; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 0)); end
        6:       begin g = 4'b0001; r = 4'b0001; exp_q.push_back(pk(1, 2'd0, 4'b0001, 0, 0, 0)); end
        7:       begin g = 4'b0000; r = 4'b0001; d = 1'b1; exp_q.push_back(pk(0, 2'd0, 4'b0000, 1, 0, 0)); end
        default: begin g = 4'b0000; r = 4'b0000; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 0)); end
      endcase
      step(g, r, d);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL preempt[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_bad_grant();
    logic [W-1:0] e, got;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] g, r;
      logic d;
      d = 1'b0;
      case (k)
        0:       begin g = 4'b0101; r = 4'b0101; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 1)); end
        1:       begin g = 4'b0000; r = 4'b0101; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 0)); end
        2:       begin g = 4'b1000; r = 4'b0000; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 0)); end
        3:       begin g = 4'b1111; r = 4'b1111; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 1)); end
        default: begin g = 4'b0000; r = 4'b1111; d = 1'b1; exp_q.push_back(pk(0, 2'd0, 4'b0000, 0, 0, 0)); end
      endcase
      step(g, r, d);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL bad_grant[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, got;
    for (int t = 0; t < 6; t++) begin
      int id, len;
      logic [N-1:0] oh, other;
      id    = $urandom_range(0, N - 1);
      len   = $urandom_range(1, 8);
      oh    = 4'b0001 << id;
      other = 4'b0001 << ((id + 1) % N);
      for (int k = 0; k <= len + 1; k++) begin
        if (k < len)       exp_q.push_back(pk(1'b1, IDW'(id), oh, 1'b0, 1'b0, 1'b0));
        else if (k == len) exp_q.push_back(pk(1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0));
        else               exp_q.push_back(pk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
        if (k == 0)          step(oh, oh | other, 1'b0);
        else if (k < len)    step(other, oh | other, 1'b0);
        else if (k == len)   step(other, oh | other, 1'b1);
        else                 step(other, other, 1'b0);
        got = outs(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin
          failures++; $display("FAIL b2b[%0d.%0d] id=%0d len=%0d got=%b exp=%b", t, k, id, len, got, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_preempt_withdraw();
    test_bad_grant();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
